// File: rtl/pwm_pkg.sv
// pwm_pkg: FSM state type and default widths shared by the PWM generator and capture blocks.
package pwm_pkg;
   localparam int CNT_W_DEF = 8;
   localparam int PRESC_W_DEF = 4;
   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} pwm_state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control inputs and measurement results of the PWM capture block.
interface pwm_capture_if import pwm_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PRESC_W = PRESC_W_DEF
);
   logic en;
   logic pwm_in;
   logic [PRESC_W-1:0] presc;
   logic [CNT_W-1:0] high_out;
   logic [CNT_W-1:0] period_out;
   logic valid;
   logic timeout;
   logic busy;
   modport master (output en, pwm_in, presc, input high_out, period_out, valid, timeout, busy);
   modport slave (input en, pwm_in, presc, output high_out, period_out, valid, timeout, busy);
endinterface

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: input synchronizer with rise/fall detection.
// Build with PWM_CAPTURE_FILTER_EN to add a 3-sample majority glitch filter after the synchronizer.
module pwm_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic rst_n,
   input logic din,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync;
   logic s, s_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= '0;
      else sync <= {sync[SYNC_STAGES-2:0], din};
`ifdef PWM_CAPTURE_FILTER_EN
   logic [1:0] flt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) flt <= '0;
      else flt <= {flt[0], sync[SYNC_STAGES-1]};
   // majority of the current synced sample and the two before it: one clock of delay per edge
   assign s = (sync[SYNC_STAGES-1] & flt[0]) | (sync[SYNC_STAGES-1] & flt[1]) | (flt[0] & flt[1]);
`else
   assign s = sync[SYNC_STAGES-1];
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s_d <= 1'b0;
      else s_d <= s;
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input in prescaled ticks.
// Optional glitch filter enabled by PWM_CAPTURE_FILTER_EN (see pwm_edge_sync).
module pwm_capture import pwm_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PRESC_W = PRESC_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic rst_n,
   pwm_capture_if.slave bus
);
   pwm_state_t state, state_n;
   logic [PRESC_W-1:0] presc_cnt, presc_n, pc;
   logic [CNT_W-1:0] high_cnt, per_cnt, high_n, per_n;
   logic [CNT_W-1:0] high_q, period_q, high_q_n, period_q_n;
   logic valid_q, valid_n, timeout_q, timeout_n;
   logic rise, fall, tick, meas, sat;

   pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst_n(rst_n), .din(bus.pwm_in), .rise(rise), .fall(fall)
   );

   assign meas = (state == MEAS_HIGH) || (state == MEAS_LOW);
   // the rise cycle is always prescaler count 0, so its tick belongs to the new period
   assign pc = rise ? '0 : presc_cnt;
   assign tick = (pc == bus.presc);
   assign sat = meas && (&per_cnt);

   always_comb begin
      state_n = state;
      high_n = high_cnt;
      per_n = per_cnt;
      high_q_n = high_q;
      period_q_n = period_q;
      valid_n = 1'b0;
      timeout_n = timeout_q;
      if (!bus.en) begin
         state_n = IDLE;
         high_n = '0;
         per_n = '0;
         timeout_n = 1'b0;
      end else if (sat) begin
         high_q_n = high_cnt;
         period_q_n = '1;
         valid_n = 1'b1;
         timeout_n = 1'b1;
         state_n = WAIT_RISE;
      end else begin
         case (state)
            IDLE: state_n = WAIT_RISE;
            WAIT_RISE: if (rise) begin
               state_n = MEAS_HIGH;
               high_n = CNT_W'(tick);
               per_n = CNT_W'(tick);
            end
            MEAS_HIGH: begin
               high_n = high_cnt + CNT_W'(tick & ~fall);
               per_n = per_cnt + CNT_W'(tick);
               state_n = fall ? MEAS_LOW : MEAS_HIGH;
            end
            MEAS_LOW: if (rise) begin
               high_q_n = high_cnt;
               period_q_n = per_cnt;
               valid_n = 1'b1;
               timeout_n = 1'b0;
               high_n = CNT_W'(tick);
               per_n = CNT_W'(tick);
               state_n = MEAS_HIGH;
            end else per_n = per_cnt + CNT_W'(tick);
         endcase
      end
      presc_n = (state_n == MEAS_HIGH || state_n == MEAS_LOW) ? (tick ? '0 : pc + 1'b1) : '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         presc_cnt <= '0;
         high_cnt <= '0;
         per_cnt <= '0;
         high_q <= '0;
         period_q <= '0;
         valid_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_n;
         presc_cnt <= presc_n;
         high_cnt <= high_n;
         per_cnt <= per_n;
         high_q <= high_q_n;
         period_q <= period_q_n;
         valid_q <= valid_n;
         timeout_q <= timeout_n;
      end

   assign bus.high_out = high_q;
   assign bus.period_out = period_q;
   assign bus.valid = valid_q;
   assign bus.timeout = timeout_q;
   assign bus.busy = meas;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture measurement, prescale, saturation, enable and glitch handling.
module tb_pwm_capture;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errs = 0;
   int checks = 0;
   int vcnt = 0;
   int base;
   logic [7:0] vhigh = '0, vper = '0;
   logic vto = 1'b0;

   pwm_capture_if bus ();
   pwm_capture dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   always @(negedge clk)
      if (bus.valid) begin
         vcnt++;
         vhigh = bus.high_out;
         vper = bus.period_out;
         vto = bus.timeout;
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wave(input int hi, input int per, input int n);
      for (int i = 0; i < n; i++) begin
         bus.pwm_in = 1'b1;
         cyc(hi);
         bus.pwm_in = 1'b0;
         cyc(per - hi);
      end
   endtask

   task automatic restart(input logic [3:0] p);
      bus.en = 1'b0;
      bus.pwm_in = 1'b0;
      cyc(6);
      bus.presc = p;
      bus.en = 1'b1;
      cyc(3);
      base = vcnt;
   endtask

   initial begin
      bus.en = 1'b0;
      bus.pwm_in = 1'b0;
      bus.presc = '0;
      for (int i = 0; i < 6; i++) begin
         bus.pwm_in = ~bus.pwm_in;
         cyc(1);
      end
      check("rst_high", bus.high_out, 0);
      check("rst_period", bus.period_out, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_timeout", bus.timeout, 0);
      check("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      base = vcnt;
      for (int i = 0; i < 20; i++) begin
         bus.pwm_in = ~bus.pwm_in;
         cyc(2);
      end
      check("idle_nvalid", vcnt - base, 0);
      check("idle_busy", bus.busy, 0);

      restart(4'd0);
      wave(3, 10, 4);
      cyc(1);
      check("basic_nvalid", vcnt - base, 3);
      check("basic_high", vhigh, 3);
      check("basic_period", vper, 10);
      check("basic_timeout", bus.timeout, 0);
      check("basic_busy", bus.busy, 1);

      restart(4'd3);
      wave(40, 100, 3);
      cyc(1);
      check("presc_nvalid", vcnt - base, 2);
      check("presc_high", vhigh, 10);
      check("presc_period", vper, 25);

      restart(4'd0);
      bus.pwm_in = 1'b1;
      cyc(300);
      check("stuck_nvalid", vcnt - base, 1);
      check("stuck_high", vhigh, 255);
      check("stuck_period", vper, 255);
      check("stuck_vto", vto, 1);
      check("stuck_timeout", bus.timeout, 1);
      check("stuck_busy", bus.busy, 0);
      bus.pwm_in = 1'b0;
      cyc(5);
      wave(50, 100, 3);
      cyc(1);
      check("recov_nvalid", vcnt - base, 3);
      check("recov_high", vhigh, 50);
      check("recov_period", vper, 100);
      check("recov_timeout", bus.timeout, 0);

      restart(4'd0);
      wave(3, 10, 2);
      check("endrop_pre_busy", bus.busy, 1);
      bus.en = 1'b0;
      cyc(1);
      check("endrop_busy", bus.busy, 0);
      bus.pwm_in = 1'b1;
      cyc(10);
      bus.pwm_in = 1'b0;
      cyc(5);
      check("endrop_nvalid", vcnt - base, 1);
      check("endrop_hold_high", bus.high_out, 3);
      check("endrop_hold_period", bus.period_out, 10);
      bus.en = 1'b1;
      cyc(3);
      wave(3, 10, 1);
      check("reen_first_rise", vcnt - base, 1);
      wave(4, 12, 1);
      check("reen_nvalid", vcnt - base, 2);
      check("reen_high", vhigh, 3);
      check("reen_period", vper, 10);

      restart(4'd0);
      for (int i = 0; i < 2; i++) begin
         bus.pwm_in = 1'b1;
         cyc(2);
         bus.pwm_in = 1'b0;
         cyc(1);
         bus.pwm_in = 1'b1;
         cyc(2);
         bus.pwm_in = 1'b0;
         cyc(15);
      end
      bus.pwm_in = 1'b1;
      cyc(5);
      bus.pwm_in = 1'b0;
      cyc(10);
`ifdef PWM_CAPTURE_FILTER_EN
      check("glitch_nvalid", vcnt - base, 2);
      check("glitch_high", vhigh, 5);
      check("glitch_period", vper, 20);
`else
      check("glitch_nvalid", vcnt - base, 4);
      check("glitch_high", vhigh, 2);
      check("glitch_period", vper, 17);
`endif

      bus.presc = 4'd1;
      wave(6, 12, 1);
      bus.pwm_in = 1'b1;
      cyc(1);
      rst_n = 1'b0;
      cyc(1);
      check("arst_busy", bus.busy, 0);
      check("arst_high", bus.high_out, 0);
      check("arst_valid", bus.valid, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
